// File: rtl/image_rgb_ycbcr_cfg.sv
// RGB to YCbCr converter with frame-synchronous mode selection.
// Four-stage free-running pipeline: S1 multiply, S2 sum, S3 round/clamp,
// S4 output format (4:4:4 or 4:2:2 interleaved chroma).
module image_rgb_ycbcr_cfg #(
  parameter int DW      = 8,
  parameter int LAT_CHK = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [DW-1:0] per_img_red,
  input  logic [DW-1:0] per_img_green,
  input  logic [DW-1:0] per_img_blue,
  input  logic [1:0]    cfg_mode,
  input  logic          cfg_422,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic [DW-1:0] post_img_Y,
  output logic [DW-1:0] post_img_Cb,
  output logic [DW-1:0] post_img_Cr,
  output logic [1:0]    post_mode
);

  localparam int P    = DW + 10;
  localparam int MAXV = (1 << DW) - 1;
  // The reserved setting 0 holds the sideband delay line idle.
  localparam bit SB_EN = (LAT_CHK != 0);

  typedef enum logic [1:0] {
    MODE_601F = 2'd0,
    MODE_601L = 2'd1,
    MODE_709L = 2'd2,
    MODE_BYP  = 2'd3
  } mode_t;

  mode_t mode_act;
  logic  c422_act;
  logic  vsync_d;

  logic [2:0] sb_in;
  logic [2:0] sb [4];

  logic signed [P-1:0] coef [9];
  logic signed [P-1:0] mul  [9];
  logic signed [P-1:0] rx, gx, bx;

  // S1
  logic signed [P-1:0] prod1 [9];
  logic [DW-1:0]       r1, g1, b1;
  mode_t               mode1;
  logic                c1;
  // S2
  logic signed [P-1:0] y2, cb2, cr2;
  logic signed [P-1:0] yoff, coff;
  logic [DW-1:0]       r2, g2, b2;
  mode_t               mode2;
  logic                c2;
  // S3
  logic [DW-1:0]       y3, cb3, cr3;
  logic                c3;
  // S4
  logic [DW-1:0]       y4, cb4, cr4;
  logic [DW-1:0]       hold;
  logic                phase;

  function automatic logic signed [P-1:0] k(input int v);
    return P'(v);
  endfunction

  function automatic logic [DW-1:0] rnd_clamp(input logic signed [P-1:0] s);
    logic signed [P-1:0] t;
    t = (s + $signed(P'(128))) >>> 8;
    if (t < 0)
      return '0;
    else if (t > $signed(P'(MAXV)))
      return '1;
    else
      return DW'(t);
  endfunction

  // Active configuration only changes on a rising edge of the input vsync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d  <= 1'b0;
      mode_act <= MODE_601F;
      c422_act <= 1'b0;
    end else begin
      vsync_d <= per_frame_vsync;
      if (per_frame_vsync && !vsync_d) begin
        mode_act <= mode_t'(cfg_mode);
        c422_act <= cfg_422;
      end
    end
  end

  assign post_mode = mode_act;

  assign sb_in = {per_frame_vsync, per_frame_href, per_frame_clken} & {3{SB_EN}};

  // Sideband delay line, one entry per pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) sb[i] <= '0;
    end else begin
      sb[0] <= sb_in;
      for (int unsigned i = 1; i < 4; i++) sb[i] <= sb[i-1];
    end
  end

  // Coefficient table for the active mode: rows Y, Cb, Cr; columns R, G, B.
  always_comb begin
    coef = '{default: '0};
    case (mode_act)
      MODE_601F: begin
        coef[0] = k(77);   coef[1] = k(150);  coef[2] = k(29);
        coef[3] = k(-43);  coef[4] = k(-85);  coef[5] = k(128);
        coef[6] = k(128);  coef[7] = k(-107); coef[8] = k(-21);
      end
      MODE_601L: begin
        coef[0] = k(66);   coef[1] = k(129);  coef[2] = k(25);
        coef[3] = k(-38);  coef[4] = k(-74);  coef[5] = k(112);
        coef[6] = k(112);  coef[7] = k(-94);  coef[8] = k(-18);
      end
      MODE_709L: begin
        coef[0] = k(47);   coef[1] = k(157);  coef[2] = k(16);
        coef[3] = k(-26);  coef[4] = k(-87);  coef[5] = k(112);
        coef[6] = k(112);  coef[7] = k(-102); coef[8] = k(-10);
      end
      default: coef = '{default: '0};
    endcase
  end

  assign rx = $signed(P'(per_img_red));
  assign gx = $signed(P'(per_img_green));
  assign bx = $signed(P'(per_img_blue));

  // Nine coefficient products feeding S1.
  always_comb begin
    mul = '{default: '0};
    for (int unsigned j = 0; j < 3; j++) begin
      mul[3*j]     = coef[3*j]     * rx;
      mul[3*j + 1] = coef[3*j + 1] * gx;
      mul[3*j + 2] = coef[3*j + 2] * bx;
    end
  end

  // S1: register products, raw components and the mode they were taken with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 9; i++) prod1[i] <= '0;
      r1 <= '0; g1 <= '0; b1 <= '0;
      mode1 <= MODE_601F;
      c1 <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 9; i++) prod1[i] <= mul[i];
      r1 <= per_img_red; g1 <= per_img_green; b1 <= per_img_blue;
      mode1 <= mode_act;
      c1 <= c422_act;
    end
  end

  assign yoff = (mode1 == MODE_601F) ? '0 : $signed(P'(16) << DW);
  assign coff = $signed(P'(128) << DW);

  // S2: accumulate each component with its offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y2 <= '0; cb2 <= '0; cr2 <= '0;
      r2 <= '0; g2 <= '0; b2 <= '0;
      mode2 <= MODE_601F;
      c2 <= 1'b0;
    end else begin
      y2  <= prod1[0] + prod1[1] + prod1[2] + yoff;
      cb2 <= prod1[3] + prod1[4] + prod1[5] + coff;
      cr2 <= prod1[6] + prod1[7] + prod1[8] + coff;
      r2 <= r1; g2 <= g1; b2 <= b1;
      mode2 <= mode1;
      c2 <= c1;
    end
  end

  // S3: round, clamp, or pass raw components through in bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y3 <= '0; cb3 <= '0; cr3 <= '0;
      c3 <= 1'b0;
    end else begin
      if (mode2 == MODE_BYP) begin
        y3 <= g2; cb3 <= b2; cr3 <= r2;
      end else begin
        y3  <= rnd_clamp(y2);
        cb3 <= rnd_clamp(cb2);
        cr3 <= rnd_clamp(cr2);
      end
      c3 <= c2;
    end
  end

  // S4: output format. Chroma phase restarts at every line; in 4:2:2 the
  // phase-0 pixel emits its Cb and parks its Cr for the next enabled pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y4 <= '0; cb4 <= '0; cr4 <= '0;
      hold <= '0;
      phase <= 1'b0;
    end else if (!sb[2][1]) begin
      y4 <= '0; cb4 <= '0; cr4 <= '0;
      phase <= 1'b0;
    end else begin
      y4 <= y3;
      if (c3) begin
        cb4 <= phase ? hold : cb3;
        cr4 <= '0;
      end else begin
        cb4 <= cb3;
        cr4 <= cr3;
      end
      if (sb[2][0]) begin
        phase <= ~phase;
        if (!phase) hold <= cr3;
      end
    end
  end

  assign post_frame_vsync = sb[3][2];
  assign post_frame_href  = sb[3][1];
  assign post_frame_clken = sb[3][0];
  assign post_img_Y       = y4;
  assign post_img_Cb      = cb4;
  assign post_img_Cr      = cr4;

endmodule

// File: tb/tb_image_rgb_ycbcr_cfg.sv
// Scoreboard bench: a DW=8 and a DW=10 instance share stimulus; a
// pixel-level reference model queues expected outputs, a monitor compares.
module tb_image_rgb_ycbcr_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       vs, hr, ck;
  logic [9:0] r, g, b;
  logic [1:0] cfg_mode;
  logic       cfg_422;

  logic       o8_vs, o8_hr, o8_ck, o10_vs, o10_hr, o10_ck;
  logic [7:0] o8_y, o8_cb, o8_cr;
  logic [9:0] o10_y, o10_cb, o10_cr;
  logic [1:0] o8_mode, o10_mode;

  image_rgb_ycbcr_cfg #(.DW(8), .LAT_CHK(1)) u8 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
    .per_img_red(r[7:0]), .per_img_green(g[7:0]), .per_img_blue(b[7:0]),
    .cfg_mode(cfg_mode), .cfg_422(cfg_422),
    .post_frame_vsync(o8_vs), .post_frame_href(o8_hr), .post_frame_clken(o8_ck),
    .post_img_Y(o8_y), .post_img_Cb(o8_cb), .post_img_Cr(o8_cr),
    .post_mode(o8_mode)
  );

  image_rgb_ycbcr_cfg #(.DW(10), .LAT_CHK(1)) u10 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
    .per_img_red(r), .per_img_green(g), .per_img_blue(b),
    .cfg_mode(cfg_mode), .cfg_422(cfg_422),
    .post_frame_vsync(o10_vs), .post_frame_href(o10_hr), .post_frame_clken(o10_ck),
    .post_img_Y(o10_y), .post_img_Cb(o10_cb), .post_img_Cr(o10_cr),
    .post_mode(o10_mode)
  );

  typedef struct { int y; int cb; int cr; } pix_t;
  typedef struct { bit v; bit h; bit c; } sb_t;

  pix_t q8[$], q10[$];
  sb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;

  int act_mode = 0;
  bit act_422 = 1'b0;
  bit prev_vs = 1'b0;
  bit phase = 1'b0;
  int hold8 = 0, hold10 = 0;

  function automatic int clampv(int v, int dw);
    if (v < 0) return 0;
    if (v > (1 << dw) - 1) return (1 << dw) - 1;
    return v;
  endfunction

  // Colour conversion straight from the published equations.
  function automatic pix_t conv(int dw, int mode, int rr, int gg, int bb);
    pix_t p;
    int off, y, cb, cr;
    off = 1 << dw;
    y = 0; cb = 0; cr = 0;
    case (mode)
      0: begin
        y  = 77*rr + 150*gg + 29*bb;
        cb = -43*rr - 85*gg + 128*bb + 128*off;
        cr = 128*rr - 107*gg - 21*bb + 128*off;
      end
      1: begin
        y  = 66*rr + 129*gg + 25*bb + 16*off;
        cb = -38*rr - 74*gg + 112*bb + 128*off;
        cr = 112*rr - 94*gg - 18*bb + 128*off;
      end
      2: begin
        y  = 47*rr + 157*gg + 16*bb + 16*off;
        cb = -26*rr - 87*gg + 112*bb + 128*off;
        cr = 112*rr - 102*gg - 10*bb + 128*off;
      end
      default: begin
        p.y = gg; p.cb = bb; p.cr = rr;
        return p;
      end
    endcase
    p.y  = clampv((y + 128) >>> 8, dw);
    p.cb = clampv((cb + 128) >>> 8, dw);
    p.cr = clampv((cr + 128) >>> 8, dw);
    return p;
  endfunction

  // Reference model: observes each sampled input cycle, queues expectations.
  always @(posedge clk) begin : model
    pix_t p8, p10, e8, e10;
    if (!rst_n) begin
      act_mode = 0; act_422 = 1'b0; prev_vs = 1'b0; phase = 1'b0;
      q8.delete(); q10.delete(); sbq.delete();
    end else begin
      sbq.push_back('{v: vs, h: hr, c: ck});
      if (hr) begin
        p8  = conv(8,  act_mode, int'(r[7:0]), int'(g[7:0]), int'(b[7:0]));
        p10 = conv(10, act_mode, int'(r), int'(g), int'(b));
        e8 = p8; e10 = p10;
        if (act_422) begin
          e8.cr = 0; e10.cr = 0;
          if (phase) begin e8.cb = hold8; e10.cb = hold10; end
        end
        if (ck) begin
          if (!phase) begin hold8 = p8.cr; hold10 = p10.cr; end
          phase = !phase;
        end
        q8.push_back(e8);
        q10.push_back(e10);
      end else begin
        phase = 1'b0;
      end
      if (vs && !prev_vs) begin
        act_mode = int'(cfg_mode);
        act_422 = cfg_422;
      end
      prev_vs = vs;
    end
  end

  // Monitor: sideband timing every cycle, pixel data whenever href is out.
  always @(negedge clk) begin : monitor
    sb_t s;
    pix_t e;
    if (rst_n) begin
      checks++;
      if (sbq.size() >= 4) begin
        s = sbq.pop_front();
        if ({o8_vs, o8_hr, o8_ck} != {s.v, s.h, s.c} || {o10_vs, o10_hr, o10_ck} != {s.v, s.h, s.c}) begin
          errors++;
          $display("FAIL sideband t=%0t got8=%b%b%b got10=%b%b%b exp=%b%b%b", $time,
                   o8_vs, o8_hr, o8_ck, o10_vs, o10_hr, o10_ck, s.v, s.h, s.c);
        end
      end else if ({o8_vs, o8_hr, o8_ck, o10_vs, o10_hr, o10_ck} != 6'b0) begin
        errors++;
        $display("FAIL sideband_fill t=%0t got8=%b%b%b got10=%b%b%b exp=000", $time,
                 o8_vs, o8_hr, o8_ck, o10_vs, o10_hr, o10_ck);
      end
      checks++;
      if (int'(o8_mode) != act_mode || int'(o10_mode) != act_mode) begin
        errors++;
        $display("FAIL post_mode t=%0t got8=%0d got10=%0d exp=%0d", $time, o8_mode, o10_mode, act_mode);
      end
      checks++;
      if (o8_hr) begin
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL pix8_unexpected t=%0t got=%0d/%0d/%0d exp=none", $time, o8_y, o8_cb, o8_cr);
        end else begin
          e = q8.pop_front();
          if (int'(o8_y) != e.y || int'(o8_cb) != e.cb || int'(o8_cr) != e.cr) begin
            errors++;
            $display("FAIL pix8 t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", $time,
                     o8_y, o8_cb, o8_cr, e.y, e.cb, e.cr);
          end
        end
      end else if ({o8_y, o8_cb, o8_cr} != '0) begin
        errors++;
        $display("FAIL pix8_blank t=%0t got=%0d/%0d/%0d exp=0/0/0", $time, o8_y, o8_cb, o8_cr);
      end
      checks++;
      if (o10_hr) begin
        if (q10.size() == 0) begin
          errors++;
          $display("FAIL pix10_unexpected t=%0t got=%0d/%0d/%0d exp=none", $time, o10_y, o10_cb, o10_cr);
        end else begin
          e = q10.pop_front();
          if (int'(o10_y) != e.y || int'(o10_cb) != e.cb || int'(o10_cr) != e.cr) begin
            errors++;
            $display("FAIL pix10 t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", $time,
                     o10_y, o10_cb, o10_cr, e.y, e.cb, e.cr);
          end
        end
      end else if ({o10_y, o10_cb, o10_cr} != '0) begin
        errors++;
        $display("FAIL pix10_blank t=%0t got=%0d/%0d/%0d exp=0/0/0", $time, o10_y, o10_cb, o10_cr);
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({o8_vs, o8_hr, o8_ck, o8_y, o8_cb, o8_cr, o8_mode} != '0 ||
        {o10_vs, o10_hr, o10_ck, o10_y, o10_cb, o10_cr, o10_mode} != '0) begin
      errors++;
      $display("FAIL %s t=%0t got8=%b%b%b %0d/%0d/%0d m%0d got10=%b%b%b %0d/%0d/%0d m%0d exp=all zero",
               name, $time, o8_vs, o8_hr, o8_ck, o8_y, o8_cb, o8_cr, o8_mode,
               o10_vs, o10_hr, o10_ck, o10_y, o10_cb, o10_cr, o10_mode);
    end
  endtask

  task automatic pix(input int rr, input int gg, input int bb, input bit c);
    hr = 1'b1; ck = c;
    r = 10'(rr); g = 10'(gg); b = 10'(bb);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    hr = 1'b0; ck = 1'b0; r = '0; g = '0; b = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start(input int m, input bit c);
    cfg_mode = 2'(m); cfg_422 = c;
    vs = 1'b1;
    idle(2);
    vs = 1'b0;
    idle(2);
  endtask

  task automatic rand_line(input int n, input bit gaps);
    for (int i = 0; i < n; i++)
      pix($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
          gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
    idle(2);
  endtask

  initial begin
    vs = 1'b0; hr = 1'b0; ck = 1'b0; r = '0; g = '0; b = '0;
    cfg_mode = 2'd0; cfg_422 = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Mode 0: white, red, then random pixels.
    frame_start(0, 1'b0);
    pix(1023, 1023, 1023, 1'b1);
    pix(255, 0, 0, 1'b1);
    rand_line(6, 1'b0);
    // Mode 1: black, white.
    frame_start(1, 1'b0);
    pix(0, 0, 0, 1'b1);
    pix(1023, 1023, 1023, 1'b1);
    rand_line(4, 1'b1);
    // Mode 2: white.
    frame_start(2, 1'b0);
    pix(1023, 1023, 1023, 1'b1);
    rand_line(4, 1'b0);
    // Mode 3 bypass.
    frame_start(3, 1'b0);
    pix(1, 2, 3, 1'b1);
    rand_line(4, 1'b0);
    // Mode request changes mid-frame; takes effect on the next vsync.
    frame_start(0, 1'b0);
    pix(200, 30, 90, 1'b1);
    cfg_mode = 2'd2;
    pix(200, 30, 90, 1'b1);
    rand_line(4, 1'b0);
    idle(4);
    frame_start(2, 1'b0);
    pix(200, 30, 90, 1'b1);
    idle(2);
    // 4:2:2: odd lines, a second line, and lines with clken gaps.
    frame_start(0, 1'b1);
    rand_line(5, 1'b0);
    rand_line(5, 1'b0);
    rand_line(7, 1'b1);
    frame_start(3, 1'b1);
    rand_line(5, 1'b0);
    // Asynchronous reset mid-line in a 4:2:2 mode 1 frame.
    frame_start(1, 1'b1);
    pix(10, 20, 30, 1'b1);
    pix(40, 50, 60, 1'b1);
    hr = 1'b1; ck = 1'b1; r = 10'd70; g = 10'd80; b = 10'd90;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    rand_line(6, 1'b0);
    rand_line(3, 1'b1);
    // Random frames.
    for (int f = 0; f < 10; f++) begin
      frame_start($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      for (int l = 0; l < 3; l++) rand_line($urandom_range(1, 9), 1'($urandom_range(0, 1)));
    end
    idle(8);
    checks++;
    if (q8.size() != 0 || q10.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0", q8.size(), q10.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_rgb_ycbcr_cfg.md
IMAGE_RGB_YCBCR_CFG -- requirements
Module: image_rgb_ycbcr_cfg

Interface
REQ-001 SHALL have parameter DW, default 8, meaning pixel component width in bits (legal 8..12).
REQ-002 SHALL have parameter LAT_CHK, default 1, meaning 1 enables the pipeline-latency sideband delay line, 0 is illegal (reserved).
REQ-003 SHALL have ports:
- clk  input  1  pixel clock
- rst_n  input  1  one clock; reset is asynchronous and active-low
- per_frame_vsync  input  1  input frame sync
- per_frame_href  input  1  input line valid
- per_frame_clken  input  1  input pixel enable
- per_img_red / per_img_green / per_img_blue  input  DW each  input RGB components
- cfg_mode  input  2  0 BT.601 full, 1 BT.601 limited, 2 BT.709 limited, 3 bypass
- cfg_422  input  1  1 selects 4:2:2 interleaved chroma output
- post_frame_vsync / post_frame_href / post_frame_clken  output  1 each  delayed sideband
- post_img_Y / post_img_Cb / post_img_Cr  output  DW each  converted components
- post_mode  output  2  mode active for current frame

Function
REQ-004 SHALL latch cfg_mode and cfg_422 into active registers only on a rising edge of per_frame_vsync; changes at other times SHALL have no effect until the next rising edge.
REQ-005 SHALL drive post_mode from the active mode register, same timing as the latch.
REQ-006 SHALL be a free-running 4-stage pipeline (S1 multiply, S2 sum, S3 round/clamp, S4 format), advancing every clk; latency exactly 4 cycles for data and all three sideband signals.
REQ-007 SHALL compute with 8-bit fractional coefficients, signed intermediates of at least DW+10 bits; OFF = 2^(DW-8).
- mode 0: Y=77R+150G+29B; Cb=-43R-85G+128B+128*OFF*256; Cr=128R-107G-21B+128*OFF*256
- mode 1: Y=66R+129G+25B+16*OFF*256; Cb=-38R-74G+112B+128*OFF*256; Cr=112R-94G-18B+128*OFF*256
- mode 2: Y=47R+157G+16B+16*OFF*256; Cb=-26R-87G+112B+128*OFF*256; Cr=112R-102G-10B+128*OFF*256
REQ-008 SHALL round by adding 128 before arithmetic shift right by 8, then clamp each result to [0, 2^DW-1].
REQ-009 In mode 3 SHALL output Y=G, Cb=B, Cr=R unmodified with the same 4-cycle latency.
REQ-010 With active cfg_422=0, SHALL output per-pixel Y, Cb, Cr (4:4:4).
REQ-011 With active cfg_422=1, SHALL keep a chroma phase bit toggled on each S3 pixel with href&clken high; phase 0 pixel outputs Cb of that pixel on post_img_Cb, phase 1 pixel outputs Cr of the preceding phase-0 pixel on post_img_Cb; post_img_Cr SHALL be 0.
REQ-012 SHALL clear the chroma phase to 0 whenever delayed href is low, so every line starts with Cb; an odd-length line ends on a Cb sample with no trailing Cr.
REQ-013 SHALL force post_img_Y/Cb/Cr to 0 whenever post_frame_href is 0.
REQ-014 Pixels with href high but clken low SHALL propagate through the pipeline but SHALL NOT toggle the chroma phase.

Reset
REQ-015 On rst_n low, SHALL immediately clear all pipeline, sideband, phase and active configuration registers; all outputs 0, post_mode=0.
REQ-016 After reset release mid-frame, active mode SHALL remain 0 (and cfg_422 0) until the next per_frame_vsync rising edge; first valid output appears 4 cycles after first input pixel.

Verification
REQ-017 DW=8, mode 0, RGB=(255,255,255) -> 4 cycles later Y=255, Cb=128, Cr=128; RGB=(255,0,0) -> Y=77, Cb=85, Cr=255 (clamped).
REQ-018 DW=8, mode 1, RGB=(0,0,0) -> Y=16, Cb=128, Cr=128; RGB=(255,255,255) -> Y=235; mode 2 white -> Y=235, Cb=127, Cr=128.
REQ-019 DW=10, mode 1, RGB=(0,0,0) -> Y=64, Cb=512, Cr=512; mode 3 RGB=(1,2,3) -> Y=2, Cb=3, Cr=1.
REQ-020 cfg_mode changed 0->2 mid-frame -> outputs and post_mode stay mode 0 until next vsync rising edge, then post_mode=2.
REQ-021 cfg_422=1, line of 5 pixels with distinct colours -> post_img_Cb sequence Cb0, Cr0, Cb2, Cr2, Cb4; post_img_Cr=0; next line restarts with Cb.
REQ-022 Assert rst_n low for 1 cycle mid-line -> all outputs 0 same cycle; post_href low for 4 cycles after resumed input.
